// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: retiring-instruction inputs from the pipeline,
// decode-stage read ports, and the forwarding/last-write views going back out.
interface wb_regfile_if;
   logic             freeze;
   logic             is_LB_SB;
   logic [0:3][7:0]  cache_data_out;
   logic [1:0]       mem_block;
   logic             mem_to_reg;
   logic [1:0]       jump;
   logic [31:0]      pc;
   logic [31:0]      alu_result;
   logic [31:0]      inst;
   logic             reg_dst;
   logic             reg_write;
   logic [4:0]       rs_addr;
   logic [4:0]       rt_addr;
   logic [31:0]      rs_data;
   logic [31:0]      rt_data;
   logic             wb_en;
   logic [4:0]       wb_addr;
   logic [31:0]      wb_data;
   logic             last_en;
   logic [4:0]       last_addr;
   logic [31:0]      last_data;
   logic [31:0]      retire_count;

   modport master (
      output freeze, is_LB_SB, cache_data_out, mem_block, mem_to_reg, jump, pc,
             alu_result, inst, reg_dst, reg_write, rs_addr, rt_addr,
      input  rs_data, rt_data, wb_en, wb_addr, wb_data,
             last_en, last_addr, last_data, retire_count
   );

   modport slave (
      input  freeze, is_LB_SB, cache_data_out, mem_block, mem_to_reg, jump, pc,
             alu_result, inst, reg_dst, reg_write, rs_addr, rt_addr,
      output rs_data, rt_data, wb_en, wb_addr, wb_data,
             last_en, last_addr, last_data, retire_count
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file with same-cycle read bypass,
// a registered copy of the last committed write, and a saturating retire counter.
module wb_regfile (
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus
);

   logic        w_link;
   logic        w_retire;
   logic        w_wb_en;
   logic [4:0]  w_dest;
   logic [7:0]  w_byte;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_data;
   logic [31:0] w_rs_data;
   logic [31:0] w_rt_data;

   logic [31:0] r_regs [0:31];
   logic        r_last_en;
   logic [4:0]  r_last_addr;
   logic [31:0] r_last_data;
   logic [31:0] r_retire_count;

   // Only 2'b10 links; the reserved 2'b11 behaves as a plain jump.
   assign w_link     = (bus.jump == 2'b10);
   assign w_retire   = (bus.inst != 32'd0) & ~bus.freeze & ~rst;
   assign w_pc_plus4 = bus.pc + 32'd4;
   assign w_byte     = bus.cache_data_out[bus.mem_block];

   always_comb begin
      w_dest = 5'd0;
      if (w_link)
         w_dest = 5'd31;
      else if (bus.reg_dst)
         w_dest = bus.inst[15:11];
      else
         w_dest = bus.inst[20:16];
   end

   always_comb begin
      w_data = bus.alu_result;
      if (w_link)
         w_data = w_pc_plus4;
      else if (bus.mem_to_reg && bus.is_LB_SB)
         w_data = {{24{w_byte[7]}}, w_byte};
      else if (bus.mem_to_reg)
         w_data = bus.cache_data_out;
   end

   assign w_wb_en = (bus.reg_write | w_link) & w_retire & (w_dest != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++)
            r_regs[i] <= 32'd0;
      end else if (w_wb_en) begin
         r_regs[w_dest] <= w_data;
      end
   end

   // w_wb_en is never set for r0, so the bypass cannot leak a value into r0 reads.
   always_comb begin
      w_rs_data = 32'd0;
      if (w_wb_en && (bus.rs_addr == w_dest))
         w_rs_data = w_data;
      else if (bus.rs_addr != 5'd0)
         w_rs_data = r_regs[bus.rs_addr];
   end

   always_comb begin
      w_rt_data = 32'd0;
      if (w_wb_en && (bus.rt_addr == w_dest))
         w_rt_data = w_data;
      else if (bus.rt_addr != 5'd0)
         w_rt_data = r_regs[bus.rt_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_en   <= 1'b0;
         r_last_addr <= 5'd0;
         r_last_data <= 32'd0;
      end else if (!bus.freeze) begin
         r_last_en   <= w_wb_en;
         r_last_addr <= w_dest;
         r_last_data <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_retire_count <= 32'd0;
      else if (w_retire && (r_retire_count != 32'hFFFF_FFFF))
         r_retire_count <= r_retire_count + 32'd1;
   end

   assign bus.rs_data      = w_rs_data;
   assign bus.rt_data      = w_rt_data;
   assign bus.wb_en        = w_wb_en;
   assign bus.wb_addr      = w_dest;
   assign bus.wb_data      = w_data;
   assign bus.last_en      = r_last_en;
   assign bus.last_addr    = r_last_addr;
   assign bus.last_data    = r_last_data;
   assign bus.retire_count = r_retire_count;

endmodule
